// File: rtl/vm1_pkg.sv
// =====================================================================
// Module   : vm1_pkg
// Brief    : Shared PSW bit indices, branch encodings, trace FSM states
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

package vm1_pkg;

   localparam int c_psw_c    = 0;
   localparam int c_psw_v    = 1;
   localparam int c_psw_z    = 2;
   localparam int c_psw_n    = 3;
   localparam int c_psw_t    = 4;
   localparam int c_psw_p_lo = 5;
   localparam int c_psw_p_hi = 7;

   // br_sel = {instr[15], instr[10:8]}
   localparam logic [3:0] c_br_never  = 4'b0000;
   localparam logic [3:0] c_br_always = 4'b0001;
   localparam logic [3:0] c_br_bne    = 4'b0010;
   localparam logic [3:0] c_br_beq    = 4'b0011;
   localparam logic [3:0] c_br_bge    = 4'b0100;
   localparam logic [3:0] c_br_blt    = 4'b0101;
   localparam logic [3:0] c_br_bgt    = 4'b0110;
   localparam logic [3:0] c_br_ble    = 4'b0111;
   localparam logic [3:0] c_br_bpl    = 4'b1000;
   localparam logic [3:0] c_br_bmi    = 4'b1001;
   localparam logic [3:0] c_br_bhi    = 4'b1010;
   localparam logic [3:0] c_br_blos   = 4'b1011;
   localparam logic [3:0] c_br_bvc    = 4'b1100;
   localparam logic [3:0] c_br_bvs    = 4'b1101;
   localparam logic [3:0] c_br_bcc    = 4'b1110;
   localparam logic [3:0] c_br_bcs    = 4'b1111;

   typedef enum logic [1:0] {
      TR_IDLE  = 2'd0,
      TR_ARMED = 2'd1,
      TR_PEND  = 2'd2
   } trace_state_t;

endpackage

`default_nettype wire

// File: rtl/vm1_brcond.sv
// =====================================================================
// Module   : vm1_brcond
// Brief    : Combinational branch condition decode from br_sel and NZVC
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module vm1_brcond
   import vm1_pkg::*;
(
   input  logic [3:0] br_sel,
   input  logic [3:0] nzvc,
   output logic       br_taken
);

   logic w_n, w_z, w_v, w_c;

   assign w_n = nzvc[c_psw_n];
   assign w_z = nzvc[c_psw_z];
   assign w_v = nzvc[c_psw_v];
   assign w_c = nzvc[c_psw_c];

   always_comb begin
      br_taken = 1'b0;
      case (br_sel)
         c_br_never  : br_taken = 1'b0;
         c_br_always : br_taken = 1'b1;
         c_br_bne    : br_taken = ~w_z;
         c_br_beq    : br_taken = w_z;
         c_br_bge    : br_taken = ~(w_n ^ w_v);
         c_br_blt    : br_taken = w_n ^ w_v;
         c_br_bgt    : br_taken = ~(w_z | (w_n ^ w_v));
         c_br_ble    : br_taken = w_z | (w_n ^ w_v);
         c_br_bpl    : br_taken = ~w_n;
         c_br_bmi    : br_taken = w_n;
         c_br_bhi    : br_taken = ~(w_c | w_z);
         c_br_blos   : br_taken = w_c | w_z;
         c_br_bvc    : br_taken = ~w_v;
         c_br_bvs    : br_taken = w_v;
         c_br_bcc    : br_taken = ~w_c;
         c_br_bcs    : br_taken = w_c;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/vm1_psw.sv
// =====================================================================
// Module   : vm1_psw
// Brief    : 1801VM1 PSW: flag merge, branch eval, trace trap, IRQ qualify.
//            Define VM1_IRQ_PRIO_EN for level-compared interrupt priority.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module vm1_psw
   import vm1_pkg::*;
#(
   parameter logic [15:0] RESET_PSW = 16'h00E0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        alu_we,
   input  logic [3:0]  alu_flags,
   input  logic [3:0]  alu_ccmask,
   input  logic        cc_we,
   input  logic        cc_set,
   input  logic [3:0]  cc_bits,
   input  logic        mtps_we,
   input  logic        psw_we,
   input  logic [15:0] psw_in,
   input  logic        rtt,
   input  logic        instr_done,
   input  logic        trace_ack,
   input  logic [3:0]  br_sel,
   input  logic        irq_pending,
   input  logic [2:0]  irq_level,
   output logic [15:0] psw,
   output logic        ni,
   output logic        ci,
   output logic        br_taken,
   output logic        trace_req,
   output logic        irq_req
);

   logic [7:0]   r_psw;
   logic [7:0]   w_psw_next;
   trace_state_t r_state;
   trace_state_t w_state_next;
   logic         r_t_new;
   logic         w_t_new_next;

   // Strobe priority: full load > MTPS > SCC/CCC > ALU
   always_comb begin
      w_psw_next = r_psw;
      if (psw_we) begin
         w_psw_next = psw_in[7:0];
      end else if (mtps_we) begin
         w_psw_next = {psw_in[c_psw_p_hi:c_psw_p_lo], r_psw[c_psw_t], psw_in[3:0]};
      end else if (cc_we) begin
         w_psw_next[3:0] = cc_set ? (r_psw[3:0] | cc_bits) : (r_psw[3:0] & ~cc_bits);
      end else if (alu_we) begin
         w_psw_next[3:0] = (r_psw[3:0] & ~alu_ccmask) | (alu_flags & alu_ccmask);
      end
   end

   // t_new marks a T=1 load by RTI/vector, which traps after one instruction
   always_comb begin
      w_t_new_next = r_t_new;
      if (instr_done) begin
         w_t_new_next = 1'b0;
      end else if (psw_we && psw_in[c_psw_t] && !rtt) begin
         w_t_new_next = 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (r_state == TR_PEND) begin
         if (trace_ack) begin
            w_state_next = TR_IDLE;
         end
      end else if (instr_done) begin
         if (r_state == TR_ARMED) begin
            w_state_next = TR_PEND;
         end else if (r_psw[c_psw_t] && r_t_new) begin
            w_state_next = TR_PEND;
         end else if (r_psw[c_psw_t]) begin
            w_state_next = TR_ARMED;
         end else begin
            w_state_next = TR_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_psw   <= RESET_PSW[7:0];
         r_state <= TR_IDLE;
         r_t_new <= 1'b0;
      end else if (ce) begin
         r_psw   <= w_psw_next;
         r_state <= w_state_next;
         r_t_new <= w_t_new_next;
      end
   end

   vm1_brcond u_brcond (
      .br_sel   (br_sel),
      .nzvc     (r_psw[3:0]),
      .br_taken (br_taken)
   );

   assign psw       = {8'h00, r_psw};
   assign ni        = r_psw[c_psw_n];
   assign ci        = r_psw[c_psw_c];
   assign trace_req = (r_state == TR_PEND);

`ifdef VM1_IRQ_PRIO_EN
   assign irq_req = irq_pending & (irq_level > r_psw[c_psw_p_hi:c_psw_p_lo]);
   logic w_unused;
   assign w_unused = ^psw_in[15:8];
`else
   assign irq_req = irq_pending & ~r_psw[c_psw_p_hi];
   logic w_unused;
   assign w_unused = ^{psw_in[15:8], irq_level};
`endif

endmodule

`default_nettype wire

// File: tb/tb_vm1_psw.sv
// =====================================================================
// Module   : tb_vm1_psw
// Brief    : Scoreboard bench for vm1_psw against a spec-level model
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module tb_vm1_psw;

   logic        clk = 1'b0;
   logic        reset, ce, alu_we, cc_we, cc_set, mtps_we, psw_we;
   logic [3:0]  alu_flags, alu_ccmask, cc_bits, br_sel;
   logic [15:0] psw_in;
   logic        rtt, instr_done, trace_ack, irq_pending;
   logic [2:0]  irq_level;
   logic [15:0] psw;
   logic        ni, ci, br_taken, trace_req, irq_req;

   always #5 clk = ~clk;

   vm1_psw #(.RESET_PSW(16'h00E0)) dut (
      .clk(clk), .reset(reset), .ce(ce),
      .alu_we(alu_we), .alu_flags(alu_flags), .alu_ccmask(alu_ccmask),
      .cc_we(cc_we), .cc_set(cc_set), .cc_bits(cc_bits),
      .mtps_we(mtps_we), .psw_we(psw_we), .psw_in(psw_in),
      .rtt(rtt), .instr_done(instr_done), .trace_ack(trace_ack),
      .br_sel(br_sel), .irq_pending(irq_pending), .irq_level(irq_level),
      .psw(psw), .ni(ni), .ci(ci), .br_taken(br_taken),
      .trace_req(trace_req), .irq_req(irq_req)
   );

   typedef struct packed {
      logic [15:0] psw;
      logic        ni, ci, br, tr, irq;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Model state: psw byte, trace mode (0 idle, 1 waiting one instr, 2 pending)
   logic [7:0] m_psw = 8'hE0;
   int         m_mode = 0;
   bit         m_tnew = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_branch(input logic [3:0] sel, input logic [7:0] p);
      bit n, z, v, c, cond;
      n = p[3]; z = p[2]; v = p[1]; c = p[0];
      case (sel >> 1)
         0: cond = 1'b1;
         1: cond = z;
         2: cond = n ^ v;
         3: cond = z | (n ^ v);
         4: cond = n;
         5: cond = c | z;
         6: cond = v;
         default: cond = c;
      endcase
      return sel[0] ? cond : !cond;
   endfunction

   function automatic bit m_irq(input logic [7:0] p, input logic pend, input logic [2:0] lvl);
`ifdef VM1_IRQ_PRIO_EN
      return pend && (int'(lvl) > int'(p >> 5));
`else
      return pend && (p < 8'h80);
`endif
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("psw", psw, e.psw);
         check("ni", {15'd0, ni}, {15'd0, e.ni});
         check("ci", {15'd0, ci}, {15'd0, e.ci});
         check("br_taken", {15'd0, br_taken}, {15'd0, e.br});
         check("trace_req", {15'd0, trace_req}, {15'd0, e.tr});
         check("irq_req", {15'd0, irq_req}, {15'd0, e.irq});
      end
   end

   // One clock: queue the expectation for current inputs, then advance model and DUT
   task automatic step(input bit chk);
      logic [7:0] n_psw;
      int         n_mode;
      bit         n_tnew;
      if (chk) begin
         exp_t e;
         e.psw = {8'h00, m_psw};
         e.ni  = m_psw[3];
         e.ci  = m_psw[0];
         e.br  = m_branch(br_sel, m_psw);
         e.tr  = (m_mode == 2);
         e.irq = m_irq(m_psw, irq_pending, irq_level);
         q.push_back(e);
      end
      @(negedge clk);
      n_psw = m_psw; n_mode = m_mode; n_tnew = m_tnew;
      if (reset) begin
         n_psw = 8'hE0; n_mode = 0; n_tnew = 0;
      end else if (ce) begin
         if (psw_we)       n_psw = psw_in[7:0];
         else if (mtps_we) n_psw = (psw_in[7:0] & 8'hEF) | (m_psw & 8'h10);
         else if (cc_we)   n_psw[3:0] = cc_set ? (m_psw[3:0] | cc_bits) : (m_psw[3:0] & ~cc_bits);
         else if (alu_we)  n_psw[3:0] = (m_psw[3:0] & ~alu_ccmask) | (alu_flags & alu_ccmask);
         if (instr_done) n_tnew = 0;
         else if (psw_we && psw_in[4] && !rtt) n_tnew = 1;
         if (m_mode == 2) begin
            if (trace_ack) n_mode = 0;
         end else if (instr_done) begin
            if (m_mode == 1)              n_mode = 2;
            else if (m_psw[4] && m_tnew)  n_mode = 2;
            else if (m_psw[4])            n_mode = 1;
            else                          n_mode = 0;
         end
      end
      @(posedge clk);
      m_psw = n_psw; m_mode = n_mode; m_tnew = n_tnew;
      #1;
   endtask

   task automatic idle();
      reset = 0; ce = 1; alu_we = 0; cc_we = 0; cc_set = 0; mtps_we = 0; psw_we = 0;
      rtt = 0; instr_done = 0; trace_ack = 0;
   endtask

   task automatic load(input logic [15:0] v, input logic r);
      idle(); psw_we = 1; psw_in = v; rtt = r; step(1); idle();
   endtask

   task automatic rand_inputs();
      reset       = ($urandom_range(0, 199) == 0);
      ce          = ($urandom_range(0, 7) != 0);
      alu_we      = ($urandom_range(0, 1) == 0);
      alu_flags   = 4'($urandom);
      alu_ccmask  = 4'($urandom);
      cc_we       = ($urandom_range(0, 3) == 0);
      cc_set      = 1'($urandom);
      cc_bits     = 4'($urandom);
      mtps_we     = ($urandom_range(0, 7) == 0);
      psw_we      = ($urandom_range(0, 9) == 0);
      psw_in      = 16'($urandom);
      rtt         = 1'($urandom);
      instr_done  = ($urandom_range(0, 2) == 0);
      trace_ack   = ($urandom_range(0, 2) == 0);
      br_sel      = 4'($urandom);
      irq_pending = 1'($urandom);
      irq_level   = 3'($urandom);
   endtask

   initial begin
      idle();
      alu_flags = 0; alu_ccmask = 0; cc_bits = 0; psw_in = 0; br_sel = 0;
      irq_pending = 0; irq_level = 0;
      reset = 1;
      step(0);
      check("reset_psw", psw, 16'h00E0);
      check("reset_trace", {15'd0, trace_req}, 16'd0);
      check("reset_nici", {14'd0, ni, ci}, 16'd0);
      idle();
      step(1);

      // Set NZVC to 0001, then masked ALU write
      cc_we = 1; cc_set = 0; cc_bits = 4'hF; step(1);
      cc_set = 1; cc_bits = 4'b0001; step(1); idle();
      alu_we = 1; alu_flags = 4'b1010; alu_ccmask = 4'b1110; step(1);
      check("alu_mask", psw, 16'h00EB);
      alu_ccmask = 4'b0000; step(1); idle();
      check("alu_mask0", psw, 16'h00EB);

      // SCC beats coincident ALU write
      cc_we = 1; cc_set = 0; cc_bits = 4'hF; step(1);
      cc_set = 1; cc_bits = 4'b0001; alu_we = 1; alu_flags = 4'b0100; alu_ccmask = 4'hF;
      step(1); idle();
      check("scc_over_alu", psw, 16'h00E1);

      // Branch sweep
      for (int f = 0; f < 16; f++) begin
         load(16'h00E0 | 16'(f), 1'b0);
         for (int s = 0; s < 16; s++) begin
            br_sel = 4'(s);
            #1;
            if (f == 8 && s == 5) check("blt_n1v0", {15'd0, br_taken}, 16'd1);
            step(1);
         end
      end

      // RTI: immediate trace after next instruction
      load(16'h0010, 1'b0);
      instr_done = 1; step(1); idle();
      check("rti_trace", {15'd0, trace_req}, 16'd1);
      step(1);
      trace_ack = 1; step(1); idle();
      check("rti_ack", {15'd0, trace_req}, 16'd0);
      load(16'h00E0, 1'b0);

      // RTT: deferred by one instruction, then reset aborts PEND
      load(16'h0010, 1'b1);
      instr_done = 1; rtt = 1; step(1); idle();
      check("rtt_armed", {15'd0, trace_req}, 16'd0);
      instr_done = 1; step(1); idle();
      check("rtt_pend", {15'd0, trace_req}, 16'd1);
      reset = 1; step(1); idle();
      check("rst_trace", {15'd0, trace_req}, 16'd0);
      check("rst_psw", psw, 16'h00E0);

      // IRQ qualification
      irq_pending = 1;
      load(16'h0080, 1'b0);
      check("irq_masked", {15'd0, irq_req}, 16'd0);
      load(16'h0060, 1'b0);
      irq_level = 3'd4; #1;
`ifdef VM1_IRQ_PRIO_EN
      check("irq_lvl4", {15'd0, irq_req}, 16'd1);
      irq_level = 3'd3; #1;
      check("irq_lvl3", {15'd0, irq_req}, 16'd0);
`else
      check("irq_p7clr", {15'd0, irq_req}, 16'd1);
`endif
      step(1);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         step(1);
      end
      idle();
      step(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
